// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: one grant per cycle,
// an issue register feeding the ALU and a response register with a ready/valid handshake.
module alu_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        r0_valid,
   input  logic        r1_valid,
   output logic        r0_ready,
   output logic        r1_ready,
   input  logic [31:0] r0_a,
   input  logic [31:0] r0_b,
   input  logic [31:0] r1_a,
   input  logic [31:0] r1_b,
   input  logic [3:0]  r0_ctrl,
   input  logic [3:0]  r1_ctrl,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_ctrl,
   input  logic [31:0] alu_result,
   input  logic        alu_carry,
   input  logic        alu_zero,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic        rsp_carry,
   output logic        rsp_zero
);

   logic        s1_valid_r;
   logic [31:0] s1_a_r;
   logic [31:0] s1_b_r;
   logic [3:0]  s1_ctrl_r;
   logic        s1_id_r;
   logic        last_r;
   logic        rsp_valid_r;
   logic        rsp_id_r;
   logic [31:0] rsp_result_r;
   logic        rsp_carry_r;
   logic        rsp_zero_r;

   logic        grant_any_s;
   logic        grant_id_s;
   logic        s2_load_s;
   logic        s1_free_s;
   logic        accept_s;

   // Winner selection from current valids and the last-grant pointer only.
   function automatic logic pick_id(input logic v0, input logic v1, input logic last);
      logic id;
      if (v0 && v1) begin
         if (RR_EN) begin
            id = ~last;
         end else begin
            id = 1'b0;
         end
      end else if (v1) begin
         id = 1'b1;
      end else begin
         id = 1'b0;
      end
      return id;
   endfunction

   // Grant, pipeline-advance and handshake decode.
   always_comb begin
      grant_any_s = 1'b0;
      grant_id_s  = 1'b0;
      s2_load_s   = 1'b0;
      s1_free_s   = 1'b0;
      accept_s    = 1'b0;
      grant_any_s = r0_valid || r1_valid;
      grant_id_s  = pick_id(r0_valid, r1_valid, last_r);
      s2_load_s   = s1_valid_r && (!rsp_valid_r || rsp_ready);
      s1_free_s   = !s1_valid_r || s2_load_s;
      accept_s    = grant_any_s && s1_free_s && rst_n;
   end

   assign r0_ready   = accept_s && !grant_id_s;
   assign r1_ready   = accept_s && grant_id_s;
   assign alu_a      = s1_valid_r ? s1_a_r : 32'd0;
   assign alu_b      = s1_valid_r ? s1_b_r : 32'd0;
   assign alu_ctrl   = s1_valid_r ? s1_ctrl_r : 4'd0;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_id     = rsp_id_r;
   assign rsp_result = rsp_result_r;
   assign rsp_carry  = rsp_carry_r;
   assign rsp_zero   = rsp_zero_r;

   // Issue stage: captures the granted operation, empties when it moves on.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_a_r     <= 32'd0;
         s1_b_r     <= 32'd0;
         s1_ctrl_r  <= 4'd0;
         s1_id_r    <= 1'b0;
      end else if (accept_s) begin
         s1_valid_r <= 1'b1;
         s1_a_r     <= grant_id_s ? r1_a : r0_a;
         s1_b_r     <= grant_id_s ? r1_b : r0_b;
         s1_ctrl_r  <= grant_id_s ? r1_ctrl : r0_ctrl;
         s1_id_r    <= grant_id_s;
      end else if (s2_load_s) begin
         s1_valid_r <= 1'b0;
      end else begin
         s1_valid_r <= s1_valid_r;
      end
   end

   // Last-grant pointer; starts at 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_r <= 1'b1;
      end else if (accept_s) begin
         last_r <= grant_id_s;
      end else begin
         last_r <= last_r;
      end
   end

   // Response stage: payload holds while the consumer stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid_r  <= 1'b0;
         rsp_id_r     <= 1'b0;
         rsp_result_r <= 32'd0;
         rsp_carry_r  <= 1'b0;
         rsp_zero_r   <= 1'b0;
      end else if (s2_load_s) begin
         rsp_valid_r  <= 1'b1;
         rsp_id_r     <= s1_id_r;
         rsp_result_r <= alu_result;
         rsp_carry_r  <= alu_carry;
         rsp_zero_r   <= alu_zero;
      end else if (rsp_ready) begin
         rsp_valid_r  <= 1'b0;
      end else begin
         rsp_valid_r  <= rsp_valid_r;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin and fixed-priority instances, a behavioural ALU,
// directed vectors/sequences and random traffic against a queue-based reference model.
module tb_alu_arbiter;

   typedef struct {
      logic        id;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  ctrl;
      int          acc;
   } op_t;

   typedef struct {
      logic        id;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  ctrl;
      logic [31:0] res;
      logic        zero;
      logic        carry;
   } vec_t;

   logic        clk;
   logic        rst_n_s;
   logic        r0_valid_s[2], r1_valid_s[2], r0_ready_s[2], r1_ready_s[2];
   logic [31:0] r0_a_s[2], r0_b_s[2], r1_a_s[2], r1_b_s[2];
   logic [3:0]  r0_ctrl_s[2], r1_ctrl_s[2];
   logic [31:0] alu_a_s[2], alu_b_s[2], alu_result_s[2];
   logic [3:0]  alu_ctrl_s[2];
   logic [32:0] alu_out_s[2];
   logic        alu_carry_s[2], alu_zero_s[2];
   logic        rsp_valid_s[2], rsp_ready_s[2], rsp_id_s[2], rsp_carry_s[2], rsp_zero_s[2];
   logic [31:0] rsp_result_s[2];

   int   checks = 0;
   int   errors = 0;
   int   cur = 0;
   int   now = 0;
   op_t  q[$];
   logic ptr = 1'b1;
   int   gq[$];
   int   acc_cnt, pop_cnt;
   logic lr_valid, lr_id, lr_zero, lr_carry, lr_r1rdy;
   logic [31:0] lr_res;
   op_t  nop;
   vec_t vt[8];

   // Reference ALU: {carry, result}; unknown codes return zero.
   function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
      case (c)
         4'd0: return {1'b0, a} + {1'b0, b};
         4'd1: return {1'b0, a - b};
         4'd2: return {1'b0, a & b};
         4'd3: return {1'b0, a | b};
         4'd4: return {1'b0, a ^ b};
         4'd5: return {32'd0, $signed(a) < $signed(b)};
         4'd6: return {32'd0, a < b};
         4'd7: return {1'b0, a << b[4:0]};
         4'd8: return {1'b0, a >> b[4:0]};
         4'd9: return {1'b0, 32'($signed(a) >>> b[4:0])};
         default: return 33'd0;
      endcase
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_alu
      assign alu_out_s[g]    = alu_fn(alu_a_s[g], alu_b_s[g], alu_ctrl_s[g]);
      assign alu_result_s[g] = alu_out_s[g][31:0];
      assign alu_carry_s[g]  = alu_out_s[g][32];
      assign alu_zero_s[g]   = (alu_out_s[g][31:0] == 32'd0);
   end

   alu_arbiter #(.RR_EN(1'b1)) u_rr (
      .clk(clk), .rst_n(rst_n_s),
      .r0_valid(r0_valid_s[0]), .r1_valid(r1_valid_s[0]),
      .r0_ready(r0_ready_s[0]), .r1_ready(r1_ready_s[0]),
      .r0_a(r0_a_s[0]), .r0_b(r0_b_s[0]), .r1_a(r1_a_s[0]), .r1_b(r1_b_s[0]),
      .r0_ctrl(r0_ctrl_s[0]), .r1_ctrl(r1_ctrl_s[0]),
      .alu_a(alu_a_s[0]), .alu_b(alu_b_s[0]), .alu_ctrl(alu_ctrl_s[0]),
      .alu_result(alu_result_s[0]), .alu_carry(alu_carry_s[0]), .alu_zero(alu_zero_s[0]),
      .rsp_valid(rsp_valid_s[0]), .rsp_ready(rsp_ready_s[0]), .rsp_id(rsp_id_s[0]),
      .rsp_result(rsp_result_s[0]), .rsp_carry(rsp_carry_s[0]), .rsp_zero(rsp_zero_s[0])
   );

   alu_arbiter #(.RR_EN(1'b0)) u_fp (
      .clk(clk), .rst_n(rst_n_s),
      .r0_valid(r0_valid_s[1]), .r1_valid(r1_valid_s[1]),
      .r0_ready(r0_ready_s[1]), .r1_ready(r1_ready_s[1]),
      .r0_a(r0_a_s[1]), .r0_b(r0_b_s[1]), .r1_a(r1_a_s[1]), .r1_b(r1_b_s[1]),
      .r0_ctrl(r0_ctrl_s[1]), .r1_ctrl(r1_ctrl_s[1]),
      .alu_a(alu_a_s[1]), .alu_b(alu_b_s[1]), .alu_ctrl(alu_ctrl_s[1]),
      .alu_result(alu_result_s[1]), .alu_carry(alu_carry_s[1]), .alu_zero(alu_zero_s[1]),
      .rsp_valid(rsp_valid_s[1]), .rsp_ready(rsp_ready_s[1]), .rsp_id(rsp_id_s[1]),
      .rsp_result(rsp_result_s[1]), .rsp_carry(rsp_carry_s[1]), .rsp_zero(rsp_zero_s[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", name, now, act, exp);
      end
   endtask

   // One cycle on the selected instance: drive, compare against the model, advance.
   task automatic step(input logic v0, input logic v1, input logic rr,
                       input op_t o0, input op_t o1);
      int   n;
      logic m_rsp, free, gany, gid, acc;
      op_t  s1, nw;
      logic s1v;
      r0_valid_s[cur] = v0;  r1_valid_s[cur] = v1;  rsp_ready_s[cur] = rr;
      r0_a_s[cur] = o0.a;  r0_b_s[cur] = o0.b;  r0_ctrl_s[cur] = o0.ctrl;
      r1_a_s[cur] = o1.a;  r1_b_s[cur] = o1.b;  r1_ctrl_s[cur] = o1.ctrl;
      #1;
      n     = q.size();
      m_rsp = (n > 0) && (q[0].acc <= now - 2);
      chk("rsp_valid", rsp_valid_s[cur], m_rsp);
      if (m_rsp) begin
         logic [32:0] e;
         e = alu_fn(q[0].a, q[0].b, q[0].ctrl);
         chk("rsp_id", rsp_id_s[cur], q[0].id);
         chk("rsp_result", rsp_result_s[cur], e[31:0]);
         chk("rsp_carry", rsp_carry_s[cur], e[32]);
         chk("rsp_zero", rsp_zero_s[cur], e[31:0] == 32'd0);
      end
      s1v = 1'b0;
      s1  = nop;
      if (n == 2) begin
         s1v = 1'b1;  s1 = q[1];
      end else if (n == 1 && q[0].acc == now - 1) begin
         s1v = 1'b1;  s1 = q[0];
      end
      chk("alu_a", alu_a_s[cur], s1v ? s1.a : 32'd0);
      chk("alu_ctrl", alu_ctrl_s[cur], s1v ? s1.ctrl : 4'd0);
      free = (n < 2) || rr;
      gany = v0 || v1;
      if (v0 && v1) gid = (cur == 0) ? ~ptr : 1'b0;
      else          gid = v1;
      acc = gany && free;
      chk("r0_ready", r0_ready_s[cur], acc && !gid);
      chk("r1_ready", r1_ready_s[cur], acc && gid);
      lr_valid = rsp_valid_s[cur];  lr_id = rsp_id_s[cur];  lr_res = rsp_result_s[cur];
      lr_zero  = rsp_zero_s[cur];   lr_carry = rsp_carry_s[cur];  lr_r1rdy = r1_ready_s[cur];
      if (v0 && r0_ready_s[cur]) begin gq.push_back(0); acc_cnt++; end
      if (v1 && r1_ready_s[cur]) begin gq.push_back(1); acc_cnt++; end
      if (rsp_valid_s[cur] && rr) pop_cnt++;
      if (m_rsp && rr) void'(q.pop_front());
      if (acc) begin
         nw = gid ? o1 : o0;
         nw.id  = gid;
         nw.acc = now;
         q.push_back(nw);
         ptr = gid;
      end
      @(negedge clk);
      now++;
   endtask

   task automatic do_reset();
      r0_valid_s[cur] = 1'b1;  r1_valid_s[cur] = 1'b1;  rsp_ready_s[cur] = 1'b1;
      rst_n_s = 1'b0;
      #1;
      chk("r0_ready_in_reset", r0_ready_s[cur], 1'b0);
      chk("r1_ready_in_reset", r1_ready_s[cur], 1'b0);
      @(negedge clk);
      rst_n_s = 1'b1;
      r0_valid_s[cur] = 1'b0;  r1_valid_s[cur] = 1'b0;
      q.delete();
      gq.delete();
      ptr = 1'b1;
      acc_cnt = 0;
      pop_cnt = 0;
      now++;
   endtask

   task automatic drain();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, nop, nop);
   endtask

   function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
      op_t o;
      o.id = 1'b0;  o.a = a;  o.b = b;  o.ctrl = c;  o.acc = 0;
      return o;
   endfunction

   function automatic op_t rnd_op();
      logic [31:0] a, b;
      a = ($urandom_range(3) == 0) ? 32'($urandom_range(4)) : $urandom;
      b = ($urandom_range(3) == 0) ? 32'($urandom_range(4)) : $urandom;
      return mk(a, b, 4'($urandom_range(15)));
   endfunction

   initial begin
      nop = mk(32'd0, 32'd0, 4'd0);
      vt[0] = '{1'b0, 32'd5, 32'd7, 4'h0, 32'd12, 1'b0, 1'b0};
      vt[1] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 4'h0, 32'd0, 1'b1, 1'b1};
      vt[2] = '{1'b1, 32'd9, 32'd9, 4'h1, 32'd0, 1'b1, 1'b0};
      vt[3] = '{1'b1, 32'hFFFF_FFFF, 32'd1, 4'h5, 32'd1, 1'b0, 1'b0};
      vt[4] = '{1'b1, 32'd1, 32'd4, 4'h7, 32'd16, 1'b0, 1'b0};
      vt[5] = '{1'b0, 32'd3, 32'd3, 4'hF, 32'd0, 1'b1, 1'b0};
      vt[6] = '{1'b0, 32'hF0F0_0000, 32'd4, 4'h8, 32'h0F0F_0000, 1'b0, 1'b0};
      vt[7] = '{1'b1, 32'h8000_0000, 32'd4, 4'h9, 32'hF800_0000, 1'b0, 1'b0};
      for (int k = 0; k < 2; k++) begin
         r0_valid_s[k] = 1'b0;  r1_valid_s[k] = 1'b0;  rsp_ready_s[k] = 1'b1;
         r0_a_s[k] = 32'd0;  r0_b_s[k] = 32'd0;  r0_ctrl_s[k] = 4'd0;
         r1_a_s[k] = 32'd0;  r1_b_s[k] = 32'd0;  r1_ctrl_s[k] = 4'd0;
      end
      rst_n_s = 1'b0;
      @(negedge clk);
      do_reset();
      for (int k = 0; k < 2; k++) begin
         chk("reset_rsp_valid", rsp_valid_s[k], 1'b0);
         chk("reset_rsp_id", rsp_id_s[k], 1'b0);
         chk("reset_rsp_result", rsp_result_s[k], 32'd0);
         chk("reset_rsp_carry", rsp_carry_s[k], 1'b0);
         chk("reset_rsp_zero", rsp_zero_s[k], 1'b0);
         chk("reset_alu_a", alu_a_s[k], 32'd0);
      end

      // Single-op vector table on the round-robin instance.
      cur = 0;
      for (int i = 0; i < 8; i++) begin
         op_t o;
         o = mk(vt[i].a, vt[i].b, vt[i].ctrl);
         if (vt[i].id) step(1'b0, 1'b1, 1'b1, nop, o);
         else          step(1'b1, 1'b0, 1'b1, o, nop);
         step(1'b0, 1'b0, 1'b1, nop, nop);
         step(1'b0, 1'b0, 1'b1, nop, nop);
         chk("vec_valid", lr_valid, 1'b1);
         chk("vec_id", lr_id, vt[i].id);
         chk("vec_result", lr_res, vt[i].res);
         chk("vec_zero", lr_zero, vt[i].zero);
         chk("vec_carry", lr_carry, vt[i].carry);
      end

      // Round-robin tie: grants alternate starting with requester 0.
      do_reset();
      for (int i = 0; i < 6; i++)
         step(1'b1, 1'b1, 1'b1, mk(32'd9, 32'd9, 4'h1), mk(32'hFFFF_FFFF, 32'd1, 4'h5));
      drain();
      chk("tie_grant_count", gq.size(), 6);
      for (int i = 0; i < gq.size(); i++) chk("tie_grant_order", gq[i], i % 2);

      // Backpressure with r1 streaming shifts.
      do_reset();
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1, nop, mk(32'd1, 32'd4, 4'h7));
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, nop, mk(32'd1, 32'd4, 4'h7));
      chk("bp_hold_valid", lr_valid, 1'b1);
      chk("bp_hold_result", lr_res, 32'd16);
      chk("bp_ready_low", lr_r1rdy, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, nop, mk(32'd1, 32'd4, 4'h7));
      drain();
      chk("bp_accepts", acc_cnt, 6);
      chk("bp_responses", pop_cnt, 6);

      // Reset mid-flight: both stages occupied, then a tie afterwards.
      do_reset();
      step(1'b1, 1'b0, 1'b1, mk(32'd1, 32'd2, 4'h0), nop);
      step(1'b0, 1'b1, 1'b1, nop, mk(32'd3, 32'd4, 4'h0));
      do_reset();
      chk("mid_reset_rsp_valid", rsp_valid_s[0], 1'b0);
      step(1'b0, 1'b0, 1'b1, nop, nop);
      step(1'b0, 1'b0, 1'b1, nop, nop);
      chk("mid_reset_no_stale", lr_valid, 1'b0);
      step(1'b1, 1'b1, 1'b1, mk(32'd2, 32'd2, 4'h0), mk(32'd5, 32'd5, 4'h0));
      drain();
      chk("mid_reset_tie_r0", (gq.size() > 0) ? gq[0] : -1, 0);

      // Fixed-priority instance: r0 wins every tie.
      cur = 1;
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, mk(32'd1, 32'd1, 4'h0), mk(32'd2, 32'd2, 4'h0));
      step(1'b0, 1'b1, 1'b1, nop, mk(32'd2, 32'd2, 4'h0));
      drain();
      chk("fp_grant_count", gq.size(), 4);
      for (int i = 0; i < gq.size(); i++) chk("fp_grant_order", gq[i], (i < 3) ? 0 : 1);

      // Random traffic on both instances.
      for (int k = 0; k < 2; k++) begin
         cur = k;
         do_reset();
         for (int i = 0; i < 500; i++) begin
            if (i == 250) do_reset();
            step(1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(9) < 7),
                 rnd_op(), rnd_op());
         end
         drain();
         chk("rand_drained", rsp_valid_s[k], 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
